// File: rtl/ifetch.sv
// ifetch: instruction fetch stage. Keeps the fetch PC, issues one request at
// a time to instruction memory over req/ack, buffers returned words in a
// 2-entry queue and presents the head to the decoder. Handles redirects
// from decode/execute and freezes on HALT until reset.
module ifetch #(
  parameter int              PCW      = 8,
  parameter logic [PCW-1:0]  RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [15:0]    imem_rdata,
  output logic [15:0]    o,
  output logic           o_valid,
  output logic [PCW-1:0] o_pc,
  input  logic           dec_ready,
  input  logic           h,
  input  logic           pcwe,
  input  logic [PCW-1:0] pc_new,
  output logic           halted
);

  localparam logic [1:0] S_IDLE = 2'd0;  // no request outstanding
  localparam logic [1:0] S_WAIT = 2'd1;  // one request outstanding
  localparam logic [1:0] S_DROP = 2'd2;  // outstanding request, data discarded
  localparam logic [1:0] S_HALT = 2'd3;  // frozen until reset

  logic [1:0]     state, state_nxt;
  logic [PCW-1:0] fetch_pc, fetch_pc_nxt;
  logic [1:0]     count, count_nxt;
  logic           req_nxt;
  logic [PCW-1:0] addr_nxt;
  logic           push, do_pop, flush;
  logic           halt_ev, redir_ev;
  logic [1:0]     wr_idx;

  logic [15:0]    q_instr [2];
  logic [PCW-1:0] q_pc    [2];

  // Head of the queue goes straight to the decoder; NOP/0 when empty.
  assign o_valid = (count != 2'd0);
  assign o       = o_valid ? q_instr[0] : 16'h0000;
  assign o_pc    = o_valid ? q_pc[0]    : '0;

  // HALT takes priority over a redirect; both only count with a valid head.
  assign halt_ev  = h & o_valid;
  assign redir_ev = pcwe & o_valid & ~h;

  // Next-state, PC and queue-control decode.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    do_pop       = 1'b0;
    flush        = 1'b0;
    if (state != S_HALT) begin
      if (halt_ev) begin
        state_nxt = S_HALT;
      end else if (redir_ev) begin
        // The redirecting instruction is consumed by the flush; any request
        // still waiting for its ack has its data thrown away in DROP.
        flush        = 1'b1;
        fetch_pc_nxt = pc_new;
        state_nxt    = (imem_req & ~imem_ack) ? S_DROP : S_IDLE;
      end else begin
        do_pop = o_valid & dec_ready;
        case (state)
          S_IDLE: begin
            if (imem_req) begin
              if (imem_ack) begin
                push         = 1'b1;
                fetch_pc_nxt = fetch_pc + 1'b1;
              end else begin
                state_nxt = S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (imem_ack) begin
              push         = 1'b1;
              fetch_pc_nxt = fetch_pc + 1'b1;
              state_nxt    = S_IDLE;
            end
          end
          S_DROP: begin
            if (imem_ack) state_nxt = S_IDLE;
          end
          default: state_nxt = state;
        endcase
      end
    end

    if (flush) count_nxt = 2'd0;
    else       count_nxt = count + {1'b0, push} - {1'b0, do_pop};

    // New word lands behind whatever survives this cycle's pop.
    wr_idx = count_nxt - 2'd1;

    // Request stays up while outstanding; a new one goes out from IDLE only
    // while the queue has room, which keeps count + outstanding <= 2.
    req_nxt  = (state_nxt == S_WAIT) || (state_nxt == S_DROP) ||
               ((state_nxt == S_IDLE) && (count_nxt != 2'd2));
    addr_nxt = (state_nxt == S_IDLE) ? fetch_pc_nxt : imem_addr;
  end

  // Control state and registered outputs, synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      count     <= 2'd0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      halted    <= 1'b0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      count     <= count_nxt;
      imem_req  <= req_nxt;
      imem_addr <= addr_nxt;
      halted    <= (state_nxt == S_HALT);
    end
  end

  // Queue storage: shift on pop, write the acked word at the tail.
  // NOTE: the data entries are not reset; count alone says which are valid
  // and the outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_pop) begin
      q_instr[0] <= q_instr[1];
      q_pc[0]    <= q_pc[1];
    end
    if (push) begin
      q_instr[wr_idx[0]] <= imem_rdata;
      q_pc[wr_idx[0]]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: self-checking bench for ifetch. A memory model with
// configurable latency answers requests; a decoder model consumes the head,
// raises pcwe at a chosen PC and h on the HALT word. The expected stream of
// consumed {pc, instr} pairs is queued up front and popped on consumption.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dec_ready;
  logic        h;
  logic        pcwe;
  logic [7:0]  pc_new;
  logic        sel;   // 0: DUT with RESET_PC=0, 1: DUT with RESET_PC=FE

  logic        a_req, b_req, a_ov, b_ov, a_halted, b_halted;
  logic [7:0]  a_addr, b_addr, a_opc, b_opc;
  logic [15:0] a_o, b_o;

  logic        imem_req, o_valid, halted;
  logic [7:0]  imem_addr, o_pc;
  logic [15:0] o;

  assign imem_req  = sel ? b_req    : a_req;
  assign imem_addr = sel ? b_addr   : a_addr;
  assign o         = sel ? b_o      : a_o;
  assign o_valid   = sel ? b_ov     : a_ov;
  assign o_pc      = sel ? b_opc    : a_opc;
  assign halted    = sel ? b_halted : a_halted;

  ifetch #(.PCW(8), .RESET_PC(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .imem_req(a_req), .imem_addr(a_addr),
    .imem_ack(imem_ack & ~sel), .imem_rdata(imem_rdata), .o(a_o),
    .o_valid(a_ov), .o_pc(a_opc), .dec_ready(dec_ready), .h(h),
    .pcwe(pcwe), .pc_new(pc_new), .halted(a_halted)
  );

  ifetch #(.PCW(8), .RESET_PC(8'hFE)) dut_b (
    .clk(clk), .rst_n(rst_n), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(imem_ack & sel), .imem_rdata(imem_rdata), .o(b_o),
    .o_valid(b_ov), .o_pc(b_opc), .dec_ready(dec_ready), .h(h),
    .pcwe(pcwe), .pc_new(pc_new), .halted(b_halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ack_log[$];

  int total = 0;
  int bad   = 0;

  // stimulus knobs
  int         lat;
  int         wcnt;
  logic       rdy_cfg;
  logic       redir_en;
  logic [7:0] redir_at;
  logic [7:0] redir_to;
  logic       redir_done;
  logic       halt_en;
  logic [7:0] halt_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic push_seq(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc    = start + 8'(i);
      e.instr = 16'h2000 | {8'h00, e.pc};
      exp_q.push_back(e);
    end
  endtask

  // One clock cycle: at the falling edge answer memory, drive the decoder
  // inputs and score any instruction consumed this cycle.
  task automatic cycle();
    @(negedge clk);
    // memory
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    if (imem_req) begin
      if (wcnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = (halt_en && imem_addr == halt_pc) ? 16'h0001
                                                       : (16'h2000 | {8'h00, imem_addr});
        wcnt       = 0;
        if (redir_done) ack_log.push_back(imem_addr);
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    // decoder
    dec_ready = rdy_cfg;
    h         = o_valid && (o == 16'h0001);
    pcwe      = 1'b0;
    pc_new    = redir_to;
    if (redir_en && o_valid && !h && o_pc == redir_at) begin
      pcwe       = 1'b1;
      redir_en   = 1'b0;
      redir_done = 1'b1;
    end
    // scoreboard
    if (o_valid && !h && (dec_ready || pcwe) && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("o_pc", {24'h0, o_pc}, {24'h0, e.pc});
      check("o", {16'h0, o}, {16'h0, e.instr});
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    ack_log.delete();
    redir_en   = 1'b0;
    redir_done = 1'b0;
    run_cycles(n);
    check("rst_req", imem_req, 0);
    check("rst_ov", o_valid, 0);
    check("rst_o", o, 0);
    check("rst_opc", o_pc, 0);
    check("rst_halted", halted, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dec_ready = 1'b0;
    h = 1'b0; pcwe = 1'b0; pc_new = '0; sel = 1'b0;
    lat = 0; wcnt = 0; rdy_cfg = 1'b1; redir_en = 1'b0; redir_at = '0;
    redir_to = '0; redir_done = 1'b0; halt_en = 1'b0; halt_pc = '0;

    // 1: zero-wait streaming, first word 2 cycles after release
    do_reset(2);
    push_seq(8'h00, 8);
    cycle();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 0);
    check("c1_ov", o_valid, 0);
    cycle();
    check("c2_ov", o_valid, 1);
    cycle();
    check("c3_opc_stream", o_pc, 1);
    drain(50);

    // 2: decoder stalled, queue fills with pc 0 and 1
    rdy_cfg = 1'b0;
    do_reset(2);
    run_cycles(5);
    check("stall_ov", o_valid, 1);
    check("stall_opc", o_pc, 0);
    check("stall_req", imem_req, 0);
    rdy_cfg = 1'b1;
    push_seq(8'h00, 5);
    drain(50);

    // 3: slow memory, redirect while the request for pc 5 is outstanding
    lat = 3;
    do_reset(2);
    push_seq(8'h00, 5);
    push_seq(8'h40, 3);
    redir_at = 8'h04; redir_to = 8'h40; redir_en = 1'b1;
    drain(200);
    check("drop_ack_n", (ack_log.size() >= 2) ? 1 : 0, 1);
    if (ack_log.size() >= 2) begin
      check("drop_ack0", ack_log[0], 8'h05);
      check("drop_ack1", ack_log[1], 8'h40);
    end

    // 4: zero-wait, redirect in the same cycle as an ack
    lat = 0;
    do_reset(2);
    push_seq(8'h00, 4);
    push_seq(8'h80, 3);
    redir_at = 8'h03; redir_to = 8'h80; redir_en = 1'b1;
    drain(50);
    check("same_ack_n", (ack_log.size() >= 1) ? 1 : 0, 1);
    if (ack_log.size() >= 1) check("same_ack0", ack_log[0], 8'h80);

    // 5: HALT freezes the stage until reset
    halt_en = 1'b1; halt_pc = 8'h06;
    do_reset(2);
    push_seq(8'h00, 6);
    drain(50);
    begin
      int n = 0;
      while (!h && n < 20) begin
        cycle();
        n++;
      end
      check("halt_seen", h, 1);
    end
    cycle();
    check("halted_t1", halted, 1);
    check("halt_req_t1", imem_req, 0);
    run_cycles(10);
    check("halted_t11", halted, 1);
    check("halt_req_t11", imem_req, 0);
    check("halt_o", o, 16'h0001);
    check("halt_ov", o_valid, 1);
    halt_en = 1'b0;
    do_reset(1);
    push_seq(8'h00, 3);
    drain(50);
    check("post_halt_halted", halted, 0);

    // 6: RESET_PC=FE, PC wraps
    sel = 1'b1;
    do_reset(2);
    push_seq(8'hFE, 4);
    cycle();
    check("fe_first_addr", imem_addr, 8'hFE);
    drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
